// File: rtl/tiny_cpu_gen.sv
// tiny_cpu_gen: parameterised accumulator-style CPU with an NREGS-entry
// register file, two-address instructions, carry/zero flags and an
// immediate field. Each instruction runs IDLE -> EXEC -> WB, giving one
// instruction per three cycles.
//
// Ports:
//   Clk           system clock, rising edge
//   Clr           asynchronous active-high reset
//   In            instruction {opcode[3:0], rd[RB], rs[RB], imm[WIDTH]}
//   In_valid      instruction present on In
//   In_ready      block can accept an instruction (IDLE only)
//   Result        last value emitted by OUT
//   Result_valid  one-cycle strobe when Result updates
//   Flag_Z        zero flag
//   Flag_C        carry/borrow flag
//   Dbg_Sel       register-file debug read index
//   Dbg_Data      combinational R[Dbg_Sel]
module tiny_cpu_gen #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int RB    = $clog2(NREGS),
    localparam int IW    = 4 + 2*RB + WIDTH
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [IW-1:0]    In,
    input  logic             In_valid,
    output logic             In_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Result_valid,
    output logic             Flag_Z,
    output logic             Flag_C,
    input  logic [RB-1:0]    Dbg_Sel,
    output logic [WIDTH-1:0] Dbg_Data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [3:0] OP_NOP  = 4'h0, OP_LDI  = 4'h1, OP_MOV = 4'h2,
                           OP_ADD  = 4'h3, OP_SUB  = 4'h4, OP_SHL = 4'h5,
                           OP_SHR  = 4'h6, OP_AND  = 4'h7, OP_OR  = 4'h8,
                           OP_XOR  = 4'h9, OP_NAND = 4'hA, OP_NOT = 4'hB,
                           OP_CMP  = 4'hC, OP_OUT  = 4'hD, OP_CLR = 4'hE,
                           OP_ADDI = 4'hF;

    state_t                      state;
    logic [IW-1:0]               ir;
    logic [NREGS-1:0][WIDTH-1:0] regs;

    // EXEC -> WB pipeline registers
    logic [WIDTH-1:0] p_res;
    logic [RB-1:0]    p_rd;
    logic             p_we, p_flags, p_c, p_z, p_out, p_clr;

    // instruction fields
    logic [3:0]       op;
    logic [RB-1:0]    rd, rs;
    logic [WIDTH-1:0] imm;
    assign op  = ir[IW-1 -: 4];
    assign rd  = ir[IW-5 -: RB];
    assign rs  = ir[IW-5-RB -: RB];
    assign imm = ir[WIDTH-1:0];

    // In_ready is a decode of the state register; gated by Clr so it
    // reads low for the whole time reset is held.
    assign In_ready = (state == IDLE) && !Clr;
    assign Dbg_Data = regs[Dbg_Sel];

    // EXEC datapath
    logic [WIDTH-1:0] a, b, n_res;
    logic [WIDTH:0]   sum, diff, sumi;
    logic             n_c, n_we, n_flags, n_out, n_clr;

    always_comb begin
        a       = regs[rd];
        b       = regs[rs];
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};   // top bit is the borrow
        sumi    = {1'b0, a} + {1'b0, imm};
        n_res   = '0;
        n_c     = 1'b0;
        n_we    = 1'b0;
        n_flags = 1'b0;
        n_out   = 1'b0;
        n_clr   = 1'b0;
        case (op)
            OP_LDI:  begin n_res = imm; n_we = 1'b1; end
            OP_MOV:  begin n_res = b;   n_we = 1'b1; end
            OP_ADD:  begin n_res = sum[WIDTH-1:0];  n_c = sum[WIDTH];  n_we = 1'b1; n_flags = 1'b1; end
            OP_SUB:  begin n_res = diff[WIDTH-1:0]; n_c = diff[WIDTH]; n_we = 1'b1; n_flags = 1'b1; end
            OP_SHL:  begin n_res = {a[WIDTH-2:0], 1'b0}; n_c = a[WIDTH-1]; n_we = 1'b1; n_flags = 1'b1; end
            OP_SHR:  begin n_res = {1'b0, a[WIDTH-1:1]}; n_c = a[0];       n_we = 1'b1; n_flags = 1'b1; end
            OP_AND:  begin n_res = a & b;    n_we = 1'b1; n_flags = 1'b1; end
            OP_OR:   begin n_res = a | b;    n_we = 1'b1; n_flags = 1'b1; end
            OP_XOR:  begin n_res = a ^ b;    n_we = 1'b1; n_flags = 1'b1; end
            OP_NAND: begin n_res = ~(a & b); n_we = 1'b1; n_flags = 1'b1; end
            OP_NOT:  begin n_res = ~a;       n_we = 1'b1; n_flags = 1'b1; end
            OP_CMP:  begin n_res = diff[WIDTH-1:0]; n_c = diff[WIDTH]; n_flags = 1'b1; end
            OP_OUT:  begin n_res = b; n_out = 1'b1; end
            OP_CLR:  n_clr = 1'b1;
            OP_ADDI: begin n_res = sumi[WIDTH-1:0]; n_c = sumi[WIDTH]; n_we = 1'b1; n_flags = 1'b1; end
            default: ;  // NOP
        endcase
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state        <= IDLE;
            ir           <= '0;
            regs         <= '0;
            Result       <= '0;
            Result_valid <= 1'b0;
            Flag_Z       <= 1'b0;
            Flag_C       <= 1'b0;
            p_res        <= '0;
            p_rd         <= '0;
            p_we         <= 1'b0;
            p_flags      <= 1'b0;
            p_c          <= 1'b0;
            p_z          <= 1'b0;
            p_out        <= 1'b0;
            p_clr        <= 1'b0;
        end else begin
            Result_valid <= 1'b0;
            case (state)
                IDLE: if (In_valid) begin
                    ir    <= In;
                    state <= EXEC;
                end
                EXEC: begin
                    p_res   <= n_res;
                    p_rd    <= rd;
                    p_we    <= n_we;
                    p_flags <= n_flags;
                    p_c     <= n_c;
                    p_z     <= (n_res == '0);
                    p_out   <= n_out;
                    p_clr   <= n_clr;
                    state   <= WB;
                end
                WB: begin
                    if (p_clr) begin
                        regs   <= '0;
                        Flag_Z <= 1'b0;
                        Flag_C <= 1'b0;
                    end else begin
                        if (p_we) regs[p_rd] <= p_res;
                        if (p_flags) begin
                            Flag_Z <= p_z;
                            Flag_C <= p_c;
                        end
                    end
                    if (p_out) begin
                        Result       <= p_res;
                        Result_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
